// File: rtl/data_mem_ctrl_if.sv
// Core data-port bus plus GPIO and TX byte-stream
// signals of the data memory controller.
interface data_mem_ctrl_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [31:0] gpio_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        tx_overflow_o;

  modport slave (
    input  ce_i, we_i, addr_i, wdata_i, tx_ready_i,
    output rdata_o, gpio_o, tx_data_o, tx_valid_o,
    output tx_overflow_o
  );

  modport master (
    output ce_i, we_i, addr_i, wdata_i, tx_ready_i,
    input  rdata_o, gpio_o, tx_data_o, tx_valid_o,
    input  tx_overflow_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data RAM with MMIO block: 64-bit cycle counter,
// GPIO register and a 4-deep TX byte FIFO.
module data_mem_ctrl #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << RAM_AW;

  localparam logic [15:0] OFF_CLO  = 16'h0000;
  localparam logic [15:0] OFF_CHI  = 16'h0004;
  localparam logic [15:0] OFF_GPIO = 16'h0008;
  localparam logic [15:0] OFF_TXD  = 16'h000C;
  localparam logic [15:0] OFF_TXS  = 16'h0010;

  logic [31:0] mem [DEPTH];
  logic [7:0]  fifo [4];

  logic [63:0] cyc_q, cyc_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] gpio_q, gpio_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  wp_q, wp_d;
  logic [1:0]  rp_q, rp_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        arm_q, arm_d;

  logic              mmio;
  logic [15:0]       off;
  logic [RAM_AW-1:0] idx;
  logic              rd;
  logic              wr;
  logic              pop;
  logic              push;
  logic              txw;
  logic              ram_we;
  logic [31:0]       status;
  logic [31:0]       rdata;

  assign mmio   = bus.addr_i[31:16] == MMIO_BASE[31:16];
  assign off    = bus.addr_i[15:0];
  assign idx    = bus.addr_i[RAM_AW+1:2];
  assign rd     = bus.ce_i & ~bus.we_i;
  // arm_q blocks writes on the first edge after reset release
  assign wr     = bus.ce_i & bus.we_i & arm_q;
  assign ram_we = wr & ~mmio;
  assign txw    = wr & mmio & (off == OFF_TXD);
  assign pop    = (cnt_q != 3'd0) & bus.tx_ready_i;
  assign push   = txw & ((cnt_q != 3'd4) | pop);

  assign status = {26'd0, ovf_q, cnt_q,
                   cnt_q == 3'd0, cnt_q == 3'd4};

  always_comb begin
    cyc_d  = cyc_q + 64'd1;
    snap_d = snap_q;
    gpio_d = gpio_q;
    ovf_d  = ovf_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q + {2'd0, push} - {2'd0, pop};
    arm_d  = 1'b1;
    if (rd & mmio & (off == OFF_CLO))
      snap_d = cyc_q[63:32];
    if (wr & mmio & (off == OFF_GPIO))
      gpio_d = bus.wdata_i;
    if (wr & mmio & (off == OFF_TXS) & bus.wdata_i[5])
      ovf_d = 1'b0;
    if (txw & ~push)
      ovf_d = 1'b1;
    if (push)
      wp_d = wp_q + 2'd1;
    if (pop)
      rp_d = rp_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q  <= '0;
      snap_q <= '0;
      gpio_q <= '0;
      ovf_q  <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      arm_q  <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      snap_q <= snap_d;
      gpio_q <= gpio_d;
      ovf_q  <= ovf_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      arm_q  <= arm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[idx] <= bus.wdata_i;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wp_q] <= bus.wdata_i[7:0];
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd & ~mmio: rdata = mem[idx];
      rd & mmio: begin
        case (off)
          OFF_CLO:  rdata = cyc_q[31:0];
          OFF_CHI:  rdata = snap_q;
          OFF_GPIO: rdata = gpio_q;
          OFF_TXS:  rdata = status;
          default:  rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

  assign bus.rdata_o       = rdata;
  assign bus.gpio_o        = gpio_q;
  assign bus.tx_data_o     = fifo[rp_q];
  assign bus.tx_valid_o    = cnt_q != 3'd0;
  assign bus.tx_overflow_o = ovf_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed table,
// corner sequences and random traffic vs a queue model.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .RAM_AW(10),
    .MMIO_BASE(32'hFFFF_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  localparam logic [31:0] CLO  = 32'hFFFF_0000;
  localparam logic [31:0] CHI  = 32'hFFFF_0004;
  localparam logic [31:0] GPIO = 32'hFFFF_0008;
  localparam logic [31:0] TXD  = 32'hFFFF_000C;
  localparam logic [31:0] TXS  = 32'hFFFF_0010;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [1024];
  logic [7:0]  q_m [$];
  logic [63:0] cyc_m;
  logic [31:0] snap_m;
  logic [31:0] gpio_m;
  logic        ovf_m;
  logic        en_m;

  typedef struct {
    logic        ce;
    logic        we;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(logic ce, logic we, logic [31:0] a,
                       logic [31:0] d, logic rdy);
    bus.ce_i       = ce;
    bus.we_i       = we;
    bus.addr_i     = a;
    bus.wdata_i    = d;
    bus.tx_ready_i = rdy;
    #1;
  endtask

  function automatic logic [31:0] exp_rd();
    logic [31:0] a;
    int n;
    a = bus.addr_i;
    n = q_m.size();
    if (!(bus.ce_i && !bus.we_i)) return 32'd0;
    if (a[31:16] != 16'hFFFF) return ram_m[a[11:2]];
    case (a[15:0])
      16'h0000: return cyc_m[31:0];
      16'h0004: return snap_m;
      16'h0008: return gpio_m;
      16'h0010: return {26'd0, ovf_m, 3'(n),
                        n == 0, n == 4};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic tick();
    logic [31:0] a;
    logic [31:0] d;
    logic rd, wr, mm, pop, push;
    a    = bus.addr_i;
    d    = bus.wdata_i;
    mm   = a[31:16] == 16'hFFFF;
    rd   = bus.ce_i && !bus.we_i;
    wr   = bus.ce_i && bus.we_i && en_m;
    pop  = q_m.size() != 0 && bus.tx_ready_i;
    push = 1'b0;
    @(posedge clk);
    if (rd && mm && a[15:0] == 16'h0000) snap_m = cyc_m[63:32];
    if (wr && !mm) ram_m[a[11:2]] = d;
    if (wr && mm && a[15:0] == 16'h0008) gpio_m = d;
    if (wr && mm && a[15:0] == 16'h0010 && d[5]) ovf_m = 1'b0;
    if (wr && mm && a[15:0] == 16'h000C) begin
      if (q_m.size() < 4 || pop) push = 1'b1;
      else ovf_m = 1'b1;
    end
    if (pop) void'(q_m.pop_front());
    if (push) q_m.push_back(d[7:0]);
    cyc_m = cyc_m + 64'd1;
    en_m  = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q_m.delete();
    cyc_m  = '0;
    snap_m = '0;
    gpio_m = '0;
    ovf_m  = 1'b0;
    en_m   = 1'b0;
  endtask

  task automatic finish_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  vec_t tbl [12];
  logic [31:0] offs [7];
  logic [7:0]  drain [4];

  initial begin
    tbl[0]  = '{1, 1, 0, 32'h0000_0040, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1, 0, 0, 32'h0000_0040, 32'h0, 32'h1234_5678};
    tbl[2]  = '{1, 0, 0, 32'h0000_1040, 32'h0, 32'h1234_5678};
    tbl[3]  = '{0, 0, 0, 32'h0000_0040, 32'h0, 32'h0};
    tbl[4]  = '{1, 1, 0, TXD, 32'h41, 32'h0};
    tbl[5]  = '{1, 1, 0, TXD, 32'h42, 32'h0};
    tbl[6]  = '{1, 1, 0, TXD, 32'h43, 32'h0};
    tbl[7]  = '{1, 1, 0, TXD, 32'h44, 32'h0};
    tbl[8]  = '{1, 1, 0, TXD, 32'h45, 32'h0};
    tbl[9]  = '{1, 0, 0, TXS, 32'h0, 32'h31};
    tbl[10] = '{1, 0, 0, TXD, 32'h0, 32'h0};
    tbl[11] = '{1, 0, 0, 32'hFFFF_0014, 32'h0, 32'h0};
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
             32'h14, 32'h100};
    drain = '{8'h42, 8'h43, 8'h44, 8'h46};

    model_reset();
    bus.ce_i = 0; bus.we_i = 0; bus.addr_i = 0;
    bus.wdata_i = 0; bus.tx_ready_i = 0;
    @(negedge clk);
    finish_reset();

    chk("rst_gpio", bus.gpio_o, 32'h0);
    chk("rst_valid", 32'(bus.tx_valid_o), 32'h0);
    chk("rst_ovf", 32'(bus.tx_overflow_o), 32'h0);
    apply(1, 0, CLO, 0, 0);
    chk("rst_cyclo", bus.rdata_o, 32'h0);
    tick();
    apply(1, 0, CHI, 0, 0);
    chk("rst_cychi", bus.rdata_o, 32'h0);
    tick();

    for (int i = 0; i < 16; i++) begin
      apply(1, 1, 32'(i) << 2, $urandom, 0);
      tick();
    end

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 1) == 1) begin
        a = CLO | offs[$urandom_range(0, 6)];
      end else begin
        a = ($urandom & 32'h7FFF_F003) |
            (32'($urandom_range(0, 15)) << 2);
      end
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            a, $urandom, $urandom_range(0, 2) == 0);
      chk("rnd_rdata", bus.rdata_o, exp_rd());
      chk("rnd_valid", 32'(bus.tx_valid_o), 32'(q_m.size() != 0));
      if (q_m.size() != 0)
        chk("rnd_txdata", 32'(bus.tx_data_o), 32'(q_m[0]));
      chk("rnd_ovf", 32'(bus.tx_overflow_o), 32'(ovf_m));
      chk("rnd_gpio", bus.gpio_o, gpio_m);
      tick();
    end

    rst = 1'b0;
    model_reset();
    apply(0, 0, 0, 0, 0);
    finish_reset();
    apply(0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ce, tbl[i].we, tbl[i].addr,
            tbl[i].wdata, tbl[i].rdy);
      chk($sformatf("tbl%0d", i), bus.rdata_o, tbl[i].exp);
      tick();
    end
    chk("hold_txdata", 32'(bus.tx_data_o), 32'h41);
    chk("full_ovf", 32'(bus.tx_overflow_o), 32'h1);

    apply(1, 1, TXD, 32'h46, 1);
    chk("full_head", 32'(bus.tx_data_o), 32'h41);
    tick();
    apply(1, 0, TXS, 0, 0);
    chk("pushpop_sts", bus.rdata_o, 32'h31);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 1);
      chk($sformatf("drain%0d", i), 32'(bus.tx_data_o),
          32'(drain[i]));
      tick();
    end
    chk("drained_valid", 32'(bus.tx_valid_o), 32'h0);
    apply(1, 0, TXS, 0, 0);
    chk("empty_sts", bus.rdata_o, 32'h22);
    tick();
    apply(1, 1, TXS, 32'h20, 0);
    tick();
    chk("ovf_clear", 32'(bus.tx_overflow_o), 32'h0);
    apply(1, 0, TXS, 0, 0);
    chk("clear_sts", bus.rdata_o, 32'h02);
    tick();
    apply(1, 0, 32'hFFFF_0014, 0, 0);
    chk("off14", bus.rdata_o, 32'h0);
    tick();

    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    apply(1, 0, CLO, 0, 0);
    chk("carry_lo", bus.rdata_o, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    force dut.cyc_q = 64'h0000_0001_0000_0000;
    apply(1, 0, CHI, 0, 0);
    chk("carry_hi", bus.rdata_o, 32'h0);
    release dut.cyc_q;
    apply(0, 0, 0, 0, 0);
    tick();

    apply(1, 1, GPIO, 32'hA5A5_A5A5, 0);
    tick();
    chk("gpio_out", bus.gpio_o, 32'hA5A5_A5A5);
    apply(1, 1, TXD, 32'h55, 0);
    tick();
    chk("pre_rst_valid", 32'(bus.tx_valid_o), 32'h1);
    apply(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_gpio", bus.gpio_o, 32'h0);
    chk("async_valid", 32'(bus.tx_valid_o), 32'h0);
    model_reset();
    finish_reset();
    apply(1, 0, CLO, 0, 0);
    chk("restart_cyc0", bus.rdata_o, 32'h0);
    apply(1, 1, GPIO, 32'h1, 0);
    tick();
    chk("release_wr_ign", bus.gpio_o, 32'h0);
    apply(1, 0, CLO, 0, 0);
    chk("restart_cyc1", bus.rdata_o, 32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning the word-address width of the internal data RAM (1024 words).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, meaning the base of the 64 KiB memory-mapped I/O region.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ce_i, input, 1 bit: access enable, driven by the core's data chip-select.
REQ-006 SHALL have port we_i, input, 1 bit: write enable, qualified by ce_i.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address.
REQ-008 SHALL have port wdata_i, input, 32 bits: store data.
REQ-009 SHALL have port rdata_o, output, 32 bits: load data, returned to the core.
REQ-010 SHALL have port gpio_o, output, 32 bits: GPIO output register.
REQ-011 SHALL have port tx_data_o, output, 8 bits: byte at the TX FIFO head.
REQ-012 SHALL have port tx_valid_o, output, 1 bit: TX FIFO not empty.
REQ-013 SHALL have port tx_ready_i, input, 1 bit: sink accepts the byte.
REQ-014 SHALL have port tx_overflow_o, output, 1 bit: sticky flag, set when a TX push is dropped.

Function
REQ-015 SHALL decode the MMIO region as addr_i[31:16]==MMIO_BASE[31:16]; every other address SHALL decode as RAM.
- RAM word index = addr_i[RAM_AW+1:2].
- addr_i[1:0] and the upper address bits are ignored, so RAM aliases.
REQ-016 SHALL map the MMIO offsets (addr_i[15:0]) as follows:
- 0x00 CYCLE_LO: read-only.
- 0x04 CYCLE_HI: read-only, returns the snapshot register.
- 0x08 GPIO: read/write.
- 0x0C TX_DATA: write-only; reads return 0.
- 0x10 TX_STATUS: read/write.
- Any other offset: reads return 0; writes are ignored.
REQ-017 SHALL make reads combinational (zero latency): rdata_o is valid in the same cycle that ce_i=1 and we_i=0.
REQ-018 SHALL drive rdata_o=0 when ce_i=0 or we_i=1.
REQ-019 SHALL commit writes (ce_i=1, we_i=1) at the next rising edge; a read of the same word in the following cycle SHALL return the new value.
REQ-020 SHALL keep a 64-bit cycle counter that increments by 1 every cycle after reset release and wraps from 2^64-1 to 0.
REQ-021 SHALL, at every edge where CYCLE_LO is read, load the snapshot register with the pre-increment counter[63:32], so that LO-then-HI reads are coherent across a carry.
REQ-022 SHALL implement TX as a 4-entry, 8-bit FIFO:
- 2-bit read and write pointers that wrap modulo 4.
- 3-bit count, range 0..4.
- tx_data_o = head entry; tx_valid_o = (count != 0).
REQ-023 SHALL push wdata_i[7:0] on a TX_DATA write when count<4, or when count==4 and a pop occurs in the same cycle.
REQ-024 SHALL drop any other TX_DATA write and set tx_overflow_o.
REQ-025 SHALL pop the FIFO at an edge where tx_valid_o=1 and tx_ready_i=1.
- On a simultaneous push and pop, count is unchanged and both pointers advance.
- When the FIFO is empty, only the push takes effect.
REQ-026 SHALL format a TX_STATUS read as: bit0=full (count==4), bit1=empty, bits[4:2]=count, bit5=tx_overflow_o, other bits 0.
REQ-027 SHALL clear tx_overflow_o on a TX_STATUS write with wdata_i[5]=1. If the same edge also drops a push, setting SHALL win.
REQ-028 SHALL hold tx_data_o stable while tx_valid_o=1 and tx_ready_i=0.

Reset
REQ-029 SHALL, while rst=0 and regardless of clk, force the following to 0: cycle counter, snapshot register, gpio_o, tx_overflow_o, FIFO pointers and count (so tx_valid_o=0).
REQ-030 SHALL leave the RAM contents and FIFO storage unreset; a reset mid-transfer discards all queued bytes.
REQ-031 SHALL treat an access coinciding with reset release as ignored for writes; reads remain combinational.

Verification
REQ-032 SHALL cover this scenario: write 0x12345678 to 0x0000_0040, then read 0x0000_0040 and its alias 0x0000_1040 -> both return 0x12345678; a read with ce_i=0 returns 0.
REQ-033 SHALL cover this scenario: force the counter to 0x0000_0000_FFFF_FFFF, read CYCLE_LO then CYCLE_HI -> LO=0xFFFFFFFF and HI=0x00000000 (the snapshot), not 0x00000001.
REQ-034 SHALL cover this scenario: with tx_ready_i=0, write 0x41..0x45 to TX_DATA -> four bytes queued, TX_STATUS=0x31 (full, count 4, overflow set), 0x45 dropped.
REQ-035 SHALL cover this scenario: FIFO full with tx_ready_i=1, write 0x46 in the same cycle -> 0x41 popped, 0x46 accepted, count stays 4, overflow unchanged; the drained order is 0x42, 0x43, 0x44, 0x46.
REQ-036 SHALL cover this scenario: write GPIO=0xA5A5A5A5, then assert rst=0 asynchronously mid-cycle -> gpio_o=0, tx_valid_o=0, and the counter restarts at 0 after release.
REQ-037 SHALL cover this scenario: write TX_STATUS with 0x20 after an overflow -> tx_overflow_o=0; reads of offset 0x14 and of TX_DATA return 0.
